// File: rtl/lsu_datamem_if.sv
// Request/response bundle between the MEM stage (master) and lsu_datamem (slave).
// Both channels use a valid/ready handshake.
interface lsu_datamem_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_datamem.sv
// Load/store data memory: byte-lane-masked stores, sign/zero-extended loads, 3-state handshake FSM.
// Define LSU_DATAMEM_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module lsu_datamem #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  lsu_datamem_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_r;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [1:0]        size_s;
  logic              legal_s;
  logic [OFF_W-1:0]  lowmask_s;
  logic [OFF_W-1:0]  offset_s;
  logic [OFF_W-1:0]  off_eff_s;
  logic [LANES-1:0]  be_base_s;
  logic [LANES-1:0]  be_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] wshift_s;
  logic [DATA_W-1:0] rword_s;
  logic [DATA_W-1:0] rshift_s;
  logic [DATA_W-1:0] ext_s;
  logic              err_s;
`ifdef LSU_DATAMEM_MISALIGN_TRAP_EN
  logic              misalign_s;
`endif

  // Decode the latched request: legality, lane mask, aligned offset and load extension.
  always_comb begin
    size_s = funct3_r[1:0];
    case (size_s)
      2'd0:    begin lowmask_s = OFF_W'(3'h0); be_base_s = LANES'(8'h01); end
      2'd1:    begin lowmask_s = OFF_W'(3'h1); be_base_s = LANES'(8'h03); end
      2'd2:    begin lowmask_s = OFF_W'(3'h3); be_base_s = LANES'(8'h0F); end
      2'd3:    begin lowmask_s = OFF_W'(3'h7); be_base_s = LANES'(8'hFF); end
      default: begin lowmask_s = OFF_W'(3'h0); be_base_s = LANES'(8'h01); end
    endcase

    // Doubleword forms only exist on the 64-bit configuration.
    if (we_r) begin
      case (funct3_r)
        3'b000, 3'b001, 3'b010: legal_s = 1'b1;
        3'b011:                 legal_s = (DATA_W == 64);
        default:                legal_s = 1'b0;
      endcase
    end else begin
      case (funct3_r)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
        3'b011, 3'b110:                         legal_s = (DATA_W == 64);
        default:                                legal_s = 1'b0;
      endcase
    end

    offset_s  = addr_r[OFF_W-1:0];
    off_eff_s = offset_s & ~lowmask_s;
`ifdef LSU_DATAMEM_MISALIGN_TRAP_EN
    misalign_s = |(offset_s & lowmask_s);
    err_s      = ~legal_s | misalign_s;
`else
    err_s      = ~legal_s;
`endif

    idx_s    = addr_r[ADDR_W-1:OFF_W];
    be_s     = be_base_s << off_eff_s;
    wshift_s = wdata_r << {off_eff_s, 3'b000};
    rword_s  = mem_r[idx_s];
    rshift_s = rword_s >> {off_eff_s, 3'b000};

    case (size_s)
      2'd0:    ext_s = funct3_r[2] ? DATA_W'(rshift_s[7:0])  : DATA_W'($signed(rshift_s[7:0]));
      2'd1:    ext_s = funct3_r[2] ? DATA_W'(rshift_s[15:0]) : DATA_W'($signed(rshift_s[15:0]));
      2'd2:    ext_s = funct3_r[2] ? DATA_W'(rshift_s[31:0]) : DATA_W'($signed(rshift_s[31:0]));
      2'd3:    ext_s = rshift_s;
      default: ext_s = rshift_s;
    endcase
  end

  // Word array: lane-masked write on the ACCESS edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if ((state_r == ACCESS) && we_r && !err_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][i*8 +: 8] <= wshift_s[i*8 +: 8];
        end
      end
    end
  end

  // Request FSM with registered response data/error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {DATA_W{1'b0}};
      rdata_r  <= {DATA_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r     <= bus.req_we;
            funct3_r <= bus.req_funct3;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            state_r  <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_r <= (we_r || err_s) ? {DATA_W{1'b0}} : ext_s;
          err_r   <= err_s;
          state_r <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;
endmodule
